// File: rtl/step_sequencer.sv
// step_sequencer: issues one start_o per job step to a timed unit and waits for done_i,
// reporting job_done_o when all steps finish or timeout_o when a step stalls.
module step_sequencer #(
  parameter  int unsigned STEP_MAX = 16,
  parameter  int unsigned TIMEOUT  = 64,
  localparam int unsigned SW       = $clog2(STEP_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_valid_i,
  input  logic [SW-1:0] job_steps_i,
  output logic          job_ready_o,
  output logic          start_o,
  input  logic          done_i,
  output logic          busy_o,
  output logic [SW-1:0] step_idx_o,
  output logic          job_done_o,
  output logic          timeout_o
);

  localparam int unsigned   TW         = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STEP_SAT   = SW'(STEP_MAX);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH,
    S_ERR
  } state_e;

  state_e        state_q;
  logic [SW-1:0] steps_q;
  logic [SW-1:0] step_idx_q;
  logic [TW-1:0] timer_q;
  logic          start_q;
  logic          busy_q;
  logic          job_done_q;
  logic          timeout_q;

  logic [SW-1:0] steps_d;
  logic [SW-1:0] last_idx;
  logic          accept;

  // Requested step count clamped to what one job may carry.
  assign steps_d  = (job_steps_i > STEP_SAT) ? STEP_SAT : job_steps_i;
  assign last_idx = steps_q - SW'(1);

  // Ready is the only output allowed to see an input (reset) directly.
  assign job_ready_o = (state_q == S_IDLE) && !rst;
  assign accept      = job_valid_i && job_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      steps_q    <= '0;
      step_idx_q <= '0;
      timer_q    <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      job_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            steps_q    <= steps_d;
            step_idx_q <= '0;
            busy_q     <= 1'b1;
            if (steps_d == '0) begin
              state_q    <= S_FINISH;
              job_done_q <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
              start_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        // A done_i arriving on the final timer cycle still counts as completion.
        S_WAIT: begin
          if (done_i) begin
            if (step_idx_q == last_idx) begin
              state_q    <= S_FINISH;
              job_done_q <= 1'b1;
            end else begin
              step_idx_q <= step_idx_q + SW'(1);
              state_q    <= S_ISSUE;
              start_q    <= 1'b1;
            end
          end else if (timer_q == TIMER_LAST) begin
            state_q   <= S_ERR;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_FINISH, S_ERR: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_o    = start_q;
  assign busy_o     = busy_q;
  assign step_idx_o = step_idx_q;
  assign job_done_o = job_done_q;
  assign timeout_o  = timeout_q;

endmodule
